// File: rtl/uart_pkg.sv
// Shared constants, state encoding and divisor helper for the UART baud engine.
//   BAUD_*      : supported table baud rates
//   calc_div    : clock divisor for a baud rate, round(clk_hz/baud)-1
//   ch_state_t  : per-channel frame sequencing state
package uart_pkg;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // Rounded divisor; the bit period is the returned value plus one clock.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud - 1;
  endfunction

endpackage

// File: rtl/baud_channel.sv
// One UART timing channel: runs FRAME_BITS bit periods after a start pulse.
//   clk, rst       : clock, synchronous active-high reset
//   div            : divisor to latch on the accepting start edge
//   start, stop    : begin frame / abort frame (stop wins)
//   busy           : frame in progress (lags the internal state by one cycle)
//   sample         : mid-bit strobe, 1 cycle
//   bit_end        : end-of-bit strobe, 1 cycle
//   done           : frame complete, coincides with the last bit_end
module baud_channel #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FRAME_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             sample,
  output logic             bit_end,
  output logic             done
);
  import uart_pkg::*;

  localparam int unsigned BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  ch_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [BIT_W-1:0] bitcnt, bitcnt_n;
  logic [CNT_W-1:0] div_q, div_n;
  logic [CNT_W-1:0] half_q, half_n;
  logic             sample_n, bit_end_n, done_n;

  // State, counters, latched divisor and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      div_q   <= '0;
      half_q  <= '0;
      busy    <= 1'b0;
      sample  <= 1'b0;
      bit_end <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bitcnt  <= bitcnt_n;
      div_q   <= div_n;
      half_q  <= half_n;
      busy    <= (state == RUN);
      sample  <= sample_n;
      bit_end <= bit_end_n;
      done    <= done_n;
    end
  end

  // Next-state, counter advance and strobe decode.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bitcnt_n  = bitcnt;
    div_n     = div_q;
    half_n    = half_q;
    sample_n  = 1'b0;
    bit_end_n = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n    = '0;
        bitcnt_n = '0;
        if (start && !stop) begin
          state_n = RUN;
          div_n   = div;
          half_n  = div >> 1;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort drops any strobe that would have fired on this edge.
          state_n  = IDLE;
          cnt_n    = '0;
          bitcnt_n = '0;
        end else begin
          sample_n = (cnt == half_q);
          if (cnt == div_q) begin
            cnt_n     = '0;
            bit_end_n = 1'b1;
            if (bitcnt == LAST_BIT) begin
              done_n   = 1'b1;
              state_n  = IDLE;
              bitcnt_n = '0;
            end else begin
              bitcnt_n = bitcnt + BIT_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_baud_engine.sv
// Two-channel (RX, TX) UART bit-timing engine.
//   clk, rst              : clock, synchronous active-high reset
//   choose                : table baud select (11=9600 10=19200 01=57600 00=115200)
//   cfg_custom, cfg_div   : use cfg_div (clamped to MIN_DIV) instead of the table
//   rx_*/tx_* start, stop : per-channel frame control
//   rx_*/tx_* busy, sample, bit_end, done : per-channel status and strobes
module uart_baud_engine #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned MIN_DIV    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       choose,
  input  logic             cfg_custom,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             rx_start,
  input  logic             rx_stop,
  output logic             rx_busy,
  output logic             rx_sample,
  output logic             rx_bit_end,
  output logic             rx_done,
  input  logic             tx_start,
  input  logic             tx_stop,
  output logic             tx_busy,
  output logic             tx_sample,
  output logic             tx_bit_end,
  output logic             tx_done
);
  import uart_pkg::*;

  // 9600 gives the largest divisor, so it alone bounds the counter width.
  if ((calc_div(CLK_HZ, BAUD_9600) >> CNT_W) != 0) begin : g_div_range
    $error("CNT_W too narrow for the 9600 baud divisor");
  end

  localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(calc_div(CLK_HZ, BAUD_9600));
  localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(calc_div(CLK_HZ, BAUD_19200));
  localparam logic [CNT_W-1:0] DIV_57600  = CNT_W'(calc_div(CLK_HZ, BAUD_57600));
  localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(calc_div(CLK_HZ, BAUD_115200));
  localparam logic [CNT_W-1:0] DIV_MIN    = CNT_W'(MIN_DIV);

  logic [CNT_W-1:0] div_sel;

  // Divisor offered to both channels; each latches it on its own start.
  always_comb begin
    div_sel = DIV_115200;
    if (cfg_custom) begin
      div_sel = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
    end else begin
      case (choose)
        2'b11:   div_sel = DIV_9600;
        2'b10:   div_sel = DIV_19200;
        2'b01:   div_sel = DIV_57600;
        default: div_sel = DIV_115200;
      endcase
    end
  end

  baud_channel #(.CNT_W(CNT_W), .FRAME_BITS(FRAME_BITS)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .div     (div_sel),
    .start   (rx_start),
    .stop    (rx_stop),
    .busy    (rx_busy),
    .sample  (rx_sample),
    .bit_end (rx_bit_end),
    .done    (rx_done)
  );

  baud_channel #(.CNT_W(CNT_W), .FRAME_BITS(FRAME_BITS)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .div     (div_sel),
    .start   (tx_start),
    .stop    (tx_stop),
    .busy    (tx_busy),
    .sample  (tx_sample),
    .bit_end (tx_bit_end),
    .done    (tx_done)
  );

endmodule

// File: tb/tb_uart_baud_engine.sv
// Scoreboard bench for uart_baud_engine: the driver predicts every strobe edge
// from the frame timing rules and queues it; the monitor pops on each strobe.
module tb_uart_baud_engine;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned MIN_DIV    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       choose;
  logic             cfg_custom;
  logic [CNT_W-1:0] cfg_div;
  logic             rx_start, rx_stop, rx_busy, rx_sample, rx_bit_end, rx_done;
  logic             tx_start, tx_stop, tx_busy, tx_sample, tx_bit_end, tx_done;

  uart_baud_engine #(
    .CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .FRAME_BITS(FRAME_BITS), .MIN_DIV(MIN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .choose(choose), .cfg_custom(cfg_custom), .cfg_div(cfg_div),
    .rx_start(rx_start), .rx_stop(rx_stop), .rx_busy(rx_busy), .rx_sample(rx_sample),
    .rx_bit_end(rx_bit_end), .rx_done(rx_done),
    .tx_start(tx_start), .tx_stop(tx_stop), .tx_busy(tx_busy), .tx_sample(tx_sample),
    .tx_bit_end(tx_bit_end), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at;
    bit s;
    bit b;
    bit d;
  } ev_t;

  ev_t q_rx[$];
  ev_t q_tx[$];
  int  run_start[2];
  int  run_end[2];
  int  rst_at = -1;
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;

  bit               p_rst = 1'b1;
  logic [1:0]       p_choose = 2'b00;
  bit               p_custom = 1'b0;
  logic [CNT_W-1:0] p_div = '0;

  // Reference divisor: nearest-integer clocks per bit, minus one.
  function automatic int model_div();
    int unsigned baud;
    if (p_custom) return (p_div < MIN_DIV) ? int'(MIN_DIV) : int'(p_div);
    case (p_choose)
      2'b11:   baud = 9600;
      2'b10:   baud = 19200;
      2'b01:   baud = 57600;
      default: baud = 115200;
    endcase
    return int'(((CLK_HZ * 2 / baud) + 1) / 2) - 1;
  endfunction

  function automatic bit running_after(input int ch, input int k);
    return (run_start[ch] <= k) && (k < run_end[ch]);
  endfunction

  function automatic int qsize(input int ch);
    return (ch == 0) ? q_rx.size() : q_tx.size();
  endfunction

  function automatic ev_t qfront(input int ch);
    return (ch == 0) ? q_rx[0] : q_tx[0];
  endfunction

  task automatic qpop(input int ch);
    if (ch == 0) void'(q_rx.pop_front());
    else         void'(q_tx.pop_front());
  endtask

  task automatic qpush(input int ch, input int at, input bit s, input bit b, input bit d);
    ev_t ev;
    ev.at = at; ev.s = s; ev.b = b; ev.d = d;
    if (ch == 0) q_rx.push_back(ev);
    else         q_tx.push_back(ev);
  endtask

  // Cancel every predicted strobe at or after edge e.
  task automatic purge(input int ch, input int e);
    if (ch == 0) while (q_rx.size() > 0 && q_rx[$].at >= e) void'(q_rx.pop_back());
    else         while (q_tx.size() > 0 && q_tx[$].at >= e) void'(q_tx.pop_back());
  endtask

  task automatic model_apply(input int ch, input int e, input bit st, input bit sp);
    int d, h;
    bit run;
    run = running_after(ch, e - 1);
    if (sp) begin
      if (run) begin
        run_end[ch] = e;
        purge(ch, e);
      end
    end else if (st && !run) begin
      d = model_div();
      h = d / 2;
      run_start[ch] = e;
      run_end[ch]   = e + FRAME_BITS * (d + 1);
      for (int k = 0; k < FRAME_BITS; k++) begin
        qpush(ch, e + h + 1 + k * (d + 1), 1'b1, 1'b0, 1'b0);
        qpush(ch, e + (k + 1) * (d + 1), 1'b0, 1'b1, k == FRAME_BITS - 1);
      end
    end
  endtask

  task automatic model_reset(input int e);
    for (int ch = 0; ch < 2; ch++) begin
      if (run_end[ch] > e) run_end[ch] = e;
      purge(ch, e);
    end
    rst_at = e;
  endtask

  // One cycle of stimulus, applied on the falling edge for the next rising edge.
  task automatic drive(input bit rs, input bit rp, input bit ts, input bit tp);
    int e;
    @(negedge clk);
    rst = p_rst; choose = p_choose; cfg_custom = p_custom; cfg_div = p_div;
    rx_start = rs; rx_stop = rp; tx_start = ts; tx_stop = tp;
    e = cyc + 1;
    if (p_rst) model_reset(e);
    else begin
      model_apply(0, e, rs, rp);
      model_apply(1, e, ts, tp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string name);
    logic [7:0] got;
    @(posedge clk);
    #2;
    got = {rx_busy, rx_sample, rx_bit_end, rx_done, tx_busy, tx_sample, tx_bit_end, tx_done};
    vectors++;
    if (got !== 8'h00) begin
      miscompares++;
      $display("FAIL %s outputs: got %b want 00000000", name, got);
    end
  endtask

  task automatic check_ch(input int ch, input int n, input logic busy,
                          input logic s, input logic b, input logic d);
    ev_t ev;
    bit exp_busy;
    string nm;
    nm = (ch == 0) ? "rx" : "tx";
    exp_busy = running_after(ch, n - 1) && (n != rst_at);
    vectors++;
    if (busy !== exp_busy) begin
      miscompares++;
      $display("FAIL %s_busy at edge %0d: got %b want %b", nm, n, busy, exp_busy);
    end
    while (qsize(ch) > 0 && qfront(ch).at < n) begin
      ev = qfront(ch);
      qpop(ch);
      vectors++;
      miscompares++;
      $display("FAIL %s_strobe missing at edge %0d: got none want s/b/d=%b%b%b",
               nm, ev.at, ev.s, ev.b, ev.d);
    end
    if ((s | b | d) !== 1'b0) begin
      vectors++;
      if (qsize(ch) > 0 && qfront(ch).at == n) begin
        ev = qfront(ch);
        qpop(ch);
        if ({s, b, d} !== {ev.s, ev.b, ev.d}) begin
          miscompares++;
          $display("FAIL %s_strobe at edge %0d: got s/b/d=%b%b%b want %b%b%b",
                   nm, n, s, b, d, ev.s, ev.b, ev.d);
        end
      end else begin
        miscompares++;
        $display("FAIL %s_strobe unexpected at edge %0d: got s/b/d=%b%b%b want 000",
                 nm, n, s, b, d);
      end
    end
  endtask

  // Monitor: edge counter plus per-edge comparison against the scoreboard.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mon_en) begin
      check_ch(0, cyc, rx_busy, rx_sample, rx_bit_end, rx_done);
      check_ch(1, cyc, tx_busy, tx_sample, tx_bit_end, tx_done);
    end
  end

  initial begin
    run_start = '{0, 0};
    run_end   = '{0, 0};

    // Reset state.
    p_rst = 1'b1;
    idle(2);
    mon_en = 1'b1;
    idle(1);
    p_rst = 1'b0;
    check_zero("reset");

    // 115200 frame on RX.
    p_choose = 2'b00;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4345);

    // 9600 frame keeps its divisor after choose changes; TX picks up the new one.
    p_choose = 2'b11;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(999);
    p_choose = 2'b00;
    idle(200);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3 * 5208 + 100 - 1201);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);

    // Custom divisor below the minimum is clamped.
    p_custom = 1'b1;
    p_div    = CNT_W'(1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(45);

    // Abort mid-frame; start+stop together while idle.
    p_custom = 1'b0;
    p_choose = 2'b00;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(299);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(500);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    idle(5);

    // Back-to-back frame from a start in the done cycle; mid-frame start ignored.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4340);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(999);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4340);

    // Reset mid-frame on both channels, then fresh frames.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(600);
    p_rst = 1'b1;
    idle(1);
    p_rst = 1'b0;
    check_zero("mid_frame_reset");
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4345);

    // Randomized control and configuration traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        p_custom = ($urandom_range(0, 4) != 0);
        p_div    = CNT_W'($urandom_range(0, 24));
        p_choose = 2'($urandom_range(0, 3));
      end
      drive($urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    idle(5);

    // Every predicted strobe must have been seen.
    for (int ch = 0; ch < 2; ch++) begin
      vectors++;
      if (qsize(ch) != 0) begin
        miscompares++;
        $display("FAIL ch%0d_leftover: got %0d pending want 0", ch, qsize(ch));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
